// File: rtl/args_chan_arb_pkg.sv
// Shared definitions for the channel arbiter: FSM encoding and channel-count helper.
package args_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic int ch_count(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/args_chan_arb_if.sv
// Request/grant bus between the requesting channels and the round-robin arbiter.
interface args_chan_arb_if #(
    parameter int N  = 2,
    parameter int BW = 8
);
    import args_pkg::*;

    // req is a level per channel. beat/done only count while c_vld=1.
    // c, c_vld, beat_cnt and tmo are registered. state/ptr are debug views.
    logic [(1<<N)-1:0] req;
    logic              beat;
    logic              done;
    logic [N-1:0]      c;
    logic              c_vld;
    logic [BW-1:0]     beat_cnt;
    logic              tmo;
    state_t            state;
    logic [N-1:0]      ptr;

    modport master (
        output req, beat, done,
        input  c, c_vld, beat_cnt, tmo, state, ptr
    );

    modport slave (
        input  req, beat, done,
        output c, c_vld, beat_cnt, tmo, state, ptr
    );

endinterface

// File: rtl/args_chan_arb_rr_pick.sv
// Rotate-priority pick: lowest set request at or after ptr, wrapping modulo CH.
module args_rr_pick #(
    parameter int N = 2
) (
    input  logic [(1<<N)-1:0] req,
    input  logic [N-1:0]      ptr,
    output logic [N-1:0]      win,
    output logic              any
);
    localparam int CH = 1 << N;

    logic [2*CH-1:0] dbl;
    logic [CH-1:0]   rot;
    logic [N-1:0]    off;

    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[CH-1:0];
        off = '0;
        // Scan downward so the lowest set offset is the one that sticks.
        for (int i = CH - 1; i >= 0; i--) begin
            if (rot[i]) off = N'(i);
        end
        win = ptr + off;
        any = |req;
    end

endmodule

// File: rtl/args_chan_arb.sv
// Round-robin channel arbiter: one owner at a time, one idle cycle between owners.
module args_chan_arb
    import args_pkg::*;
#(
    parameter int N         = 2,
    parameter int BW        = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic         clk,
    input  logic         rst,
    args_chan_arb_if.slave bus
);
    localparam int CH = ch_count(N);
    localparam logic [BW-1:0] LAST = BW'((MAX_BEATS == 0) ? 0 : MAX_BEATS - 1);

    state_t        state;
    logic [N-1:0]  ptr;
    logic [N-1:0]  c_q;
    logic          vld_q;
    logic [BW-1:0] cnt_q;
    logic          tmo_q;

    logic [N-1:0]  win;
    logic          any;
    logic          rel_done;
    logic          rel_drop;
    logic          rel_tmo;

    args_rr_pick #(.N(N)) u_pick (
        .req (bus.req),
        .ptr (ptr),
        .win (win),
        .any (any)
    );

    always_comb begin
        rel_done = bus.done;
        rel_drop = ~bus.req[c_q];
        rel_tmo  = (MAX_BEATS != 0) && bus.beat && (cnt_q == LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= '0;
            c_q   <= '0;
            vld_q <= 1'b0;
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= 1'b0;
            case (state)
                OWN: begin
                    if (bus.beat && (cnt_q != {BW{1'b1}})) cnt_q <= cnt_q + BW'(1);
                    if (rel_done || rel_drop || rel_tmo) begin
                        vld_q <= 1'b0;
                        ptr   <= c_q + N'(1);
                        // tmo only when the beat budget is the sole reason to let go.
                        tmo_q <= rel_tmo && !rel_done && !rel_drop;
                        state <= GAP;
                    end
                end
                default: begin
                    // IDLE and the gap cycle both arbitrate with the updated ptr.
                    if (any) begin
                        c_q   <= win;
                        vld_q <= 1'b1;
                        cnt_q <= '0;
                        state <= OWN;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.c        = c_q;
    assign bus.c_vld    = vld_q;
    assign bus.beat_cnt = cnt_q;
    assign bus.tmo      = tmo_q;
    assign bus.state    = state;
    assign bus.ptr      = ptr;

endmodule

// File: tb/tb_args_chan_arb.sv
// Bench for args_chan_arb: directed scenarios then randomized traffic against a reference model.
module tb_args_chan_arb;
    localparam int N    = 2;
    localparam int BW   = 8;
    localparam int MAXB = 4;
    localparam int CH   = 4;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    args_chan_arb_if #(.N(N), .BW(BW)) bus ();

    args_chan_arb #(.N(N), .BW(BW), .MAX_BEATS(MAXB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: who owns, how many beats, where the rotation starts next.
    int m_c;
    int m_cnt;
    int m_ptr;
    bit m_own;
    bit m_tmo;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < CH; k++) begin
            if (r[(p + k) % CH]) return (p + k) % CH;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int  w;
        bit  by_done;
        bit  by_drop;
        bit  by_tmo;
        if (!rst) begin
            m_c = 0; m_cnt = 0; m_ptr = 0; m_own = 0; m_tmo = 0;
        end else begin
            m_tmo = 0;
            if (m_own) begin
                by_done = bus.done;
                by_drop = !bus.req[m_c];
                by_tmo  = bus.beat && (m_cnt == MAXB - 1);
                if (bus.beat && m_cnt < 255) m_cnt = m_cnt + 1;
                if (by_done || by_drop || by_tmo) begin
                    m_own = 0;
                    m_ptr = (m_c + 1) % CH;
                    m_tmo = by_tmo && !by_done && !by_drop;
                end
            end else begin
                w = pick(bus.req, m_ptr);
                if (w >= 0) begin
                    m_own = 1; m_c = w; m_cnt = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic settle();
        bus.req = '0; bus.beat = 0; bus.done = 0;
        repeat (3) tick();
    endtask

    task automatic do_reset();
        rst = 0; bus.req = '0; bus.beat = 0; bus.done = 0;
        tick();
        rst = 1;
    endtask

    task automatic test_reset();
        rst = 0; bus.req = 4'b1111; bus.beat = 0; bus.done = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (bus.c !== 2'd0 || bus.c_vld !== 1'b0 || bus.beat_cnt !== 8'd0 || bus.tmo !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d c=%0d vld=%b cnt=%0d tmo=%b exp 0/0/0/0",
                         i, bus.c, bus.c_vld, bus.beat_cnt, bus.tmo);
            end
        end
        rst = 1;
        tick();
        checks++;
        if (bus.c_vld !== 1'b1 || bus.c !== 2'd0) begin
            errors++;
            $display("FAIL reset_first_grant c=%0d vld=%b exp c=0 vld=1", bus.c, bus.c_vld);
        end
        settle();
    endtask

    task automatic test_single();
        bus.req = 4'b0100;
        tick();
        checks++;
        if (bus.c_vld !== 1'b1 || bus.c !== 2'd2 || bus.beat_cnt !== 8'd0) begin
            errors++;
            $display("FAIL single_grant c=%0d vld=%b cnt=%0d exp c=2 vld=1 cnt=0",
                     bus.c, bus.c_vld, bus.beat_cnt);
        end
        bus.beat = 1;
        tick();
        tick();
        bus.beat = 0; bus.done = 1;
        tick();
        bus.done = 0;
        checks++;
        if (bus.c_vld !== 1'b0 || bus.beat_cnt !== 8'd2 || bus.tmo !== 1'b0 ||
            bus.ptr !== 2'd3 || bus.c !== 2'd2) begin
            errors++;
            $display("FAIL single_release vld=%b cnt=%0d tmo=%b ptr=%0d c=%0d exp 0/2/0/3/2",
                     bus.c_vld, bus.beat_cnt, bus.tmo, bus.ptr, bus.c);
        end
        settle();
    endtask

    task automatic test_round_robin();
        do_reset();
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (bus.c_vld !== 1'b1 || bus.c !== 2'(k % CH)) begin
                errors++;
                $display("FAIL rr_grant k=%0d c=%0d vld=%b exp c=%0d vld=1", k, bus.c, bus.c_vld, k % CH);
            end
            bus.done = 1;
            tick();
            bus.done = 0;
            checks++;
            if (bus.c_vld !== 1'b0) begin
                errors++;
                $display("FAIL rr_gap k=%0d vld=%b exp 0", k, bus.c_vld);
            end
        end
        settle();
    endtask

    task automatic test_timeout();
        do_reset();
        bus.req = 4'b0011; bus.beat = 1;
        tick();
        repeat (3) tick();
        checks++;
        if (bus.c_vld !== 1'b1 || bus.c !== 2'd0 || bus.beat_cnt !== 8'd3 || bus.tmo !== 1'b0) begin
            errors++;
            $display("FAIL tmo_before c=%0d vld=%b cnt=%0d tmo=%b exp 0/1/3/0",
                     bus.c, bus.c_vld, bus.beat_cnt, bus.tmo);
        end
        tick();
        checks++;
        if (bus.c_vld !== 1'b0 || bus.tmo !== 1'b1 || bus.beat_cnt !== 8'd4) begin
            errors++;
            $display("FAIL tmo_pulse vld=%b tmo=%b cnt=%0d exp 0/1/4", bus.c_vld, bus.tmo, bus.beat_cnt);
        end
        tick();
        checks++;
        if (bus.c_vld !== 1'b1 || bus.c !== 2'd1 || bus.tmo !== 1'b0 || bus.beat_cnt !== 8'd0) begin
            errors++;
            $display("FAIL tmo_next c=%0d vld=%b tmo=%b cnt=%0d exp 1/1/0/0",
                     bus.c, bus.c_vld, bus.tmo, bus.beat_cnt);
        end
        settle();
    endtask

    task automatic test_drop_precedence();
        bus.req = 4'b0010;
        tick();
        bus.beat = 1;
        tick();
        bus.beat = 0; bus.req = 4'b0000;
        tick();
        checks++;
        if (bus.c_vld !== 1'b0 || bus.tmo !== 1'b0 || bus.c !== 2'd1) begin
            errors++;
            $display("FAIL drop_release c=%0d vld=%b tmo=%b exp 1/0/0", bus.c, bus.c_vld, bus.tmo);
        end
        settle();
        bus.req = 4'b0100;
        tick();
        bus.beat = 1;
        repeat (3) tick();
        bus.done = 1;
        tick();
        bus.beat = 0; bus.done = 0;
        checks++;
        if (bus.c_vld !== 1'b0 || bus.tmo !== 1'b0 || bus.beat_cnt !== 8'd4 || bus.c !== 2'd2) begin
            errors++;
            $display("FAIL done_vs_tmo c=%0d vld=%b tmo=%b cnt=%0d exp 2/0/0/4",
                     bus.c, bus.c_vld, bus.tmo, bus.beat_cnt);
        end
        settle();
    endtask

    task automatic test_reset_mid();
        bus.req = 4'b1000;
        tick();
        checks++;
        if (bus.c_vld !== 1'b1 || bus.c !== 2'd3) begin
            errors++;
            $display("FAIL mid_setup c=%0d vld=%b exp c=3 vld=1", bus.c, bus.c_vld);
        end
        rst = 0; bus.beat = 1;
        tick();
        rst = 1; bus.beat = 0;
        checks++;
        if (bus.c !== 2'd0 || bus.c_vld !== 1'b0 || bus.ptr !== 2'd0 || bus.tmo !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset c=%0d vld=%b ptr=%0d tmo=%b exp 0/0/0/0",
                     bus.c, bus.c_vld, bus.ptr, bus.tmo);
        end
        bus.req = 4'b1001;
        tick();
        checks++;
        if (bus.c !== 2'd0 || bus.c_vld !== 1'b1) begin
            errors++;
            $display("FAIL mid_regrant c=%0d vld=%b exp c=0 vld=1", bus.c, bus.c_vld);
        end
        settle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
            bus.beat = ($urandom_range(0, 3) != 0);
            bus.done = ($urandom_range(0, 9) == 0);
            rst      = ($urandom_range(0, 99) != 0);
            tick();
            checks++;
            if (bus.c !== 2'(m_c) || bus.c_vld !== m_own || bus.beat_cnt !== 8'(m_cnt) ||
                bus.tmo !== m_tmo || bus.ptr !== 2'(m_ptr)) begin
                errors++;
                $display("FAIL random cyc=%0d c=%0d vld=%b cnt=%0d tmo=%b ptr=%0d exp %0d/%b/%0d/%b/%0d",
                         i, bus.c, bus.c_vld, bus.beat_cnt, bus.tmo, bus.ptr,
                         m_c, m_own, m_cnt, m_tmo, m_ptr);
            end
        end
        rst = 1;
        settle();
    endtask

    initial begin
        errors = 0; checks = 0;
        m_c = 0; m_cnt = 0; m_ptr = 0; m_own = 0; m_tmo = 0;
        rst = 0; bus.req = '0; bus.beat = 0; bus.done = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_drop_precedence();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
